// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer-width convention, default synchroniser depth
// and Gray/binary conversions used by both the read and write pointer blocks.
package fifo_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int CONV_W          = 32;

    // Pointer width is one bit wider than the RAM address to carry the wrap bit.
    function automatic int ptr_w(input int addr_size);
        return addr_size + 1;
    endfunction

    // Narrower pointers are zero-extended to CONV_W on entry and cast back by the caller.
    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
        logic [CONV_W-1:0] b;
        b[CONV_W-1] = g[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Width-parameterised multi-flop synchroniser for Gray pointers crossing clock domains.
module ptr_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/read_ptr.sv
// Read-domain pointer and empty-flag generator for the async FIFO.
// Optional almost-empty flag enabled by defining READ_PTR_ALMOST_EMPTY_EN.
module read_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE   = 2,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int AE_THRESH   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_SIZE:0]   wr_ptr_i,
    input  logic                 inc_i,
    output logic [ADDR_SIZE:0]   ptr_o,
    output logic [ADDR_SIZE-1:0] addr_o,
    output logic                 fifo_empty_o
`ifdef READ_PTR_ALMOST_EMPTY_EN
    ,
    output logic                 almost_empty_o
`endif
);

    localparam int PTR_W = ptr_w(ADDR_SIZE);

    logic [PTR_W-1:0]     r_rbin;
    logic [PTR_W-1:0]     r_ptr;
    logic [ADDR_SIZE-1:0] r_addr;
    logic                 r_empty;

    logic             w_rd_en;
    logic [PTR_W-1:0] w_rbin_next;
    logic [PTR_W-1:0] w_rgray_next;
    logic [PTR_W-1:0] w_wq_gray;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (wr_ptr_i),
        .o_q   (w_wq_gray)
    );

    // Empty gates the increment so a request on an empty FIFO never moves the pointer.
    assign w_rd_en      = inc_i & ~r_empty;
    assign w_rbin_next  = r_rbin + PTR_W'(w_rd_en);
    assign w_rgray_next = PTR_W'(bin2gray(CONV_W'(w_rbin_next)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rbin  <= '0;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_empty <= 1'b1;
        end else begin
            r_rbin  <= w_rbin_next;
            r_ptr   <= w_rgray_next;
            r_addr  <= w_rbin_next[ADDR_SIZE-1:0];
            r_empty <= (w_rgray_next == w_wq_gray);
        end
    end

    assign ptr_o        = r_ptr;
    assign addr_o       = r_addr;
    assign fifo_empty_o = r_empty;

`ifdef READ_PTR_ALMOST_EMPTY_EN
    logic [PTR_W-1:0] w_wq_bin;
    logic [PTR_W-1:0] w_level;
    logic             r_almost_empty;

    // Level is taken against the post-read count, matching the empty compare.
    assign w_wq_bin = PTR_W'(gray2bin(CONV_W'(w_wq_gray)));
    assign w_level  = w_wq_bin - w_rbin_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_empty <= (w_level <= PTR_W'(AE_THRESH));
        end
    end

    assign almost_empty_o = r_almost_empty;
`endif

endmodule

// File: tb/tb_read_ptr.sv
// Directed plus randomised bench for read_ptr against a word-count reference model.
module tb_read_ptr;

    localparam int ADDR_SIZE = 2;
    localparam int DEPTH     = 1 << ADDR_SIZE;
    localparam int MODN      = 2 * DEPTH;
    localparam int AE        = 1;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [2:0] wr_ptr_i = 3'b000;
    logic       inc_i = 1'b0;
    logic [2:0] ptr_o;
    logic [1:0] addr_o;
    logic       fifo_empty_o;
`ifdef READ_PTR_ALMOST_EMPTY_EN
    logic       almost_empty_o;
`endif

    int total = 0;
    int bad   = 0;

    // Model: words written/read as counts mod 2*DEPTH, plus a delay line of write counts.
    int wcount  = 0;
    int m_rcnt  = 0;
    bit m_empty = 1;
    bit m_ae    = 1;
    int m_dly1  = 0;
    int m_dly2  = 0;

    read_ptr #(
        .ADDR_SIZE   (ADDR_SIZE),
        .SYNC_STAGES (2),
        .AE_THRESH   (AE)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_ptr_i     (wr_ptr_i),
        .inc_i        (inc_i),
        .ptr_o        (ptr_o),
        .addr_o       (addr_o),
        .fifo_empty_o (fifo_empty_o)
`ifdef READ_PTR_ALMOST_EMPTY_EN
        ,
        .almost_empty_o (almost_empty_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [2:0] to_gray(input int n);
        int m;
        m = n % MODN;
        return 3'(m ^ (m >> 1));
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit inc);
        int nr;
        int lvl;
        rst_i    = rst;
        inc_i    = inc;
        wr_ptr_i = to_gray(wcount);
        @(posedge clk_i);
        if (rst) begin
            m_rcnt  = 0;
            m_empty = 1;
            m_ae    = 1;
            m_dly1  = 0;
            m_dly2  = 0;
        end else begin
            nr      = (m_rcnt + ((inc && !m_empty) ? 1 : 0)) % MODN;
            m_empty = (nr == m_dly2);
            lvl     = (m_dly2 - nr + MODN) % MODN;
            m_ae    = (lvl <= AE);
            m_rcnt  = nr;
            m_dly2  = m_dly1;
            m_dly1  = wcount % MODN;
        end
        #1;
        check("ptr",   int'(ptr_o),        int'(to_gray(m_rcnt)));
        check("addr",  int'(addr_o),       m_rcnt % DEPTH);
        check("empty", int'(fifo_empty_o), int'(m_empty));
`ifdef READ_PTR_ALMOST_EMPTY_EN
        check("aempty", int'(almost_empty_o), int'(m_ae));
`endif
    endtask

    initial begin
        // 1: reset with a non-zero write pointer present
        wcount = 3;
        step(1, 0);
        step(1, 1);
        check("rst_ptr_const", int'(ptr_o), 0);
        check("rst_empty_const", int'(fifo_empty_o), 1);

        // 2: empty FIFO ignores read requests
        wcount = 0;
        for (int i = 0; i < 10; i++) step(0, 1);
        check("idle_ptr_const", int'(ptr_o), 0);

        // 3: three words, drain to empty
        wcount = 3;
        step(0, 1);
        step(0, 1);
        step(0, 1);
        check("drop_empty_const", int'(fifo_empty_o), 0);
        step(0, 1);
        check("rd1_ptr_const", int'(ptr_o), 3'b001);
        step(0, 1);
        check("rd2_ptr_const", int'(ptr_o), 3'b011);
        step(0, 1);
        check("rd3_ptr_const", int'(ptr_o), 3'b010);
        check("rd3_empty_const", int'(fifo_empty_o), 1);
        step(0, 1);
        check("hold_ptr_const", int'(ptr_o), 3'b010);

        // 4: wrap through the MSB
        wcount = 4;
        for (int i = 0; i < 8; i++) step(0, 1);
        check("wrap1_ptr_const", int'(ptr_o), 3'b110);
        wcount = 8;
        for (int i = 0; i < 8; i++) step(0, 1);
        check("wrap2_ptr_const", int'(ptr_o), 3'b000);
        check("wrap2_empty_const", int'(fifo_empty_o), 1);

        // 5: reset after two reads
        wcount = 11;
        for (int i = 0; i < 5; i++) step(0, 1);
        check("mid_ptr_const", int'(ptr_o), 3'b011);
        step(1, 1);
        check("midrst_empty_const", int'(fifo_empty_o), 1);
        for (int i = 0; i < 8; i++) step(0, 1);
        check("post_rst_ptr_const", int'(ptr_o), 3'b010);

`ifdef READ_PTR_ALMOST_EMPTY_EN
        // 6: almost-empty thresholds
        step(1, 0);
        wcount = 3;
        for (int i = 0; i < 3; i++) step(0, 0);
        check("ae_lvl3_const", int'(almost_empty_o), 0);
        step(0, 1);
        step(0, 1);
        check("ae_lvl1_const", int'(almost_empty_o), 1);
        check("ae_lvl1_empty_const", int'(fifo_empty_o), 0);
        step(0, 1);
        check("ae_lvl0_const", int'(almost_empty_o), 1);
`endif

        // Randomised traffic with an occasional reset of both domains
        for (int i = 0; i < 2000; i++) begin
            bit r;
            r = ($urandom_range(0, 99) == 0);
            if (r) begin
                wcount = 0;
            end else if ($urandom_range(0, 2) != 0 &&
                         ((wcount - m_rcnt + 4 * MODN) % MODN) < DEPTH) begin
                wcount = (wcount + 1) % MODN;
            end
            step(r, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/read_ptr.md
Name: read_ptr

Overview:
- Read-side pointer and empty-flag generator for the async FIFO; counterpart of the write pointer block.
- Runs entirely in the read clock domain.
- Keeps a binary read counter and publishes its Gray-coded pointer to the write domain.
- Synchronises the incoming Gray write pointer, drives the RAM read address and raises the empty flag.

Parameters:
- ADDR_SIZE, 2, RAM address width; FIFO depth = 2^ADDR_SIZE.
- SYNC_STAGES, 2, flop stages synchronising wr_ptr_i into the read clock domain; minimum 2.
- AE_THRESH, 1, almost-empty threshold in words; used only with the optional feature.

Ports:
- clk_i  in  1  read clock.
- rst_i  in  1  synchronous, active-high reset.
- wr_ptr_i  in  ADDR_SIZE+1  Gray write pointer from the write domain; asynchronous to clk_i.
- inc_i  in  1  read request; a word is consumed on a clock edge where inc_i=1 and fifo_empty_o=0.
- ptr_o  out  ADDR_SIZE+1  registered Gray read pointer, sent to the write domain.
- addr_o  out  ADDR_SIZE  registered RAM read address.
- fifo_empty_o  out  1  registered empty flag.
- almost_empty_o  out  1  present only with READ_PTR_ALMOST_EMPTY_EN.

Behaviour:
- Reset, sampled at a clk_i edge with rst_i=1:
  - binary counter rbin=0, ptr_o=0, addr_o=0.
  - All synchroniser stages cleared to 0.
  - fifo_empty_o=1; almost_empty_o=1.
  - Reset takes priority over inc_i. Reset mid-operation abandons the current state with no partial update.
- Counter update:
  - rd_en = inc_i & ~fifo_empty_o.
  - rbin_next = rbin + rd_en, modulo 2^(ADDR_SIZE+1).
  - rgray_next = rbin_next ^ (rbin_next >> 1).
  - On each edge: rbin<=rbin_next, ptr_o<=rgray_next, addr_o<=rbin_next[ADDR_SIZE-1:0].
- Synchroniser:
  - wr_ptr_i passes through SYNC_STAGES flops; the last stage is wq_gray.
  - No logic sits between stages.
  - Only Gray values cross, so each sample is either the old or the new pointer.
- Empty flag:
  - fifo_empty_o <= (rgray_next == wq_gray).
  - Full-width compare including the MSB wrap bit.
  - A read that consumes the last word asserts empty on the same edge that advances the pointer, so no over-read is possible.
- inc_i while empty is ignored; the pointer holds.
- Latency:
  - A wr_ptr_i change is visible on fifo_empty_o SYNC_STAGES+1 edges later (3 edges at the default).
  - A read is visible on ptr_o 1 edge after the consuming edge.
- Wrap-around:
  - addr_o wraps every 2^ADDR_SIZE reads.
  - ptr_o returns to 0 after 2^(ADDR_SIZE+1) reads; Gray changes exactly one bit per read, including at wrap.
- Simultaneous events: a read and a write-pointer change on the same edge need no special case. Empty is evaluated against the current wq_gray; the newer write is seen later, which is pessimistic and safe.

Optional Feature:
- Macro: READ_PTR_ALMOST_EMPTY_EN.
- With the macro:
  - wq_gray is converted to binary wq_bin.
  - level = (wq_bin - rbin_next) mod 2^(ADDR_SIZE+1).
  - almost_empty_o <= (level <= AE_THRESH), registered; reset value 1.
  - Same synchroniser latency as fifo_empty_o.
- Without the macro: the almost_empty_o port, the gray-to-binary conversion and the subtractor are absent; all other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterised by width;
  - PTR_W = ADDR_SIZE+1 convention;
  - default SYNC_STAGES constant.
- The write pointer block uses the same package.
- Sub-module ptr_sync: SYNC_STAGES-deep, width-parameterised flop chain with synchronous reset. It is instantiated here and is reused by the write side for the read pointer.

Test Plan (ADDR_SIZE=2, SYNC_STAGES=2):
1. rst_i=1 for 2 cycles, wr_ptr_i=3'b010 -> ptr_o=000, addr_o=00, fifo_empty_o=1 throughout reset.
2. After reset: wr_ptr_i=000, inc_i=1 for 10 cycles -> ptr_o stays 000, addr_o stays 00, fifo_empty_o stays 1.
3. Reads up to empty:
   - Stimulus: wr_ptr_i=010 (3 words written), inc_i=1.
   - fifo_empty_o drops on the 3rd edge after the change.
   - Then ptr_o steps 001, 011, 010 and addr_o steps 01, 10, 11.
   - fifo_empty_o=1 on the same edge ptr_o becomes 010; ptr_o holds there.
4. Wrap:
   - Stimulus: wr_ptr_i=110 (binary 4), drain 4 -> ptr_o=110, addr_o=00, empty=1.
   - Then wr_ptr_i=000 (binary 8, wrapped), drain 4 -> ptr_o sequence 111, 101, 100, 000; addr_o 01, 10, 11, 00; empty=1 at the end.
5. Reset mid-operation: after 2 reads with wr_ptr_i=010, pulse rst_i for 1 cycle -> next edge ptr_o=000 and empty=1. After release, empty drops 3 edges later and 3 reads are again possible.
6. With READ_PTR_ALMOST_EMPTY_EN and AE_THRESH=1:
   - wr_ptr_i=010 (level 3) -> almost_empty_o=0 after 3 edges.
   - Read 2 -> level 1, almost_empty_o=1 with fifo_empty_o=0.
   - Read 1 more -> both flags 1.
